// File: rtl/div_pipe_arbiter_if.sv
// Requester, divider and response signals of the shared-divider arbiter.
// The master side is the requesters plus the divider; the slave side is the arbiter.
interface div_pipe_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_dividend;
  logic [8*N_REQ-1:0] req_divisor;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         div_dividend;
  logic [7:0]         div_divisor;
  logic [7:0]         div_quotient;
  logic [7:0]         div_remainder;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_quotient;
  logic [7:0]         rsp_remainder;
  logic               rsp_dz;
  logic [3:0]         inflight;

  modport master (
    output req_valid, req_dividend, req_divisor, div_quotient, div_remainder,
    input  req_ready, div_dividend, div_divisor, rsp_valid, rsp_quotient,
           rsp_remainder, rsp_dz, inflight
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_quotient, div_remainder,
    output req_ready, div_dividend, div_divisor, rsp_valid, rsp_quotient,
           rsp_remainder, rsp_dz, inflight
  );
endinterface

// File: rtl/div_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined 8-bit signed divider; result returns PIPE_LAT+1 cycles after issue.
// Backpressure: one outstanding op per requester; req_ready is withheld until that requester's response cycle.
module div_pipe_arbiter #(
  parameter int N_REQ    = 4,
  parameter int PIPE_LAT = 10,
  parameter int TAG_W    = 2
) (
  input logic               clk,
  input logic               rst_n,
  div_pipe_arbiter_if.slave bus
);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } shadow_t;

  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] rsp_onehot;
  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] gnt_idx;
  logic             issue;
  logic [7:0]       sel_dividend;
  logic [7:0]       sel_divisor;
  shadow_t          sh [PIPE_LAT];
  shadow_t          last;

  assign eligible = bus.req_valid & ~busy;
  assign last     = sh[PIPE_LAT-1];

  // Grant is held off while reset is asserted so req_ready reads 0 even with requests pending.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    issue   = 1'b0;
    if (rst_n) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!issue && eligible[(int'(ptr) + k) % N_REQ]) begin
          issue                            = 1'b1;
          gnt_idx                          = TAG_W'((int'(ptr) + k) % N_REQ);
          grant[(int'(ptr) + k) % N_REQ]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_dividend = bus.req_dividend[8*i +: 8];
        sel_divisor  = bus.req_divisor[8*i +: 8];
      end
    end
  end

  assign bus.req_ready    = grant;
  assign bus.div_dividend = sel_dividend;
  assign bus.div_divisor  = sel_divisor;
  assign rsp_onehot       = last.vld ? (N_REQ'(1) << last.tag) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr               <= '0;
      busy              <= '0;
      bus.inflight      <= '0;
      bus.rsp_valid     <= '0;
      bus.rsp_quotient  <= '0;
      bus.rsp_remainder <= '0;
      bus.rsp_dz        <= 1'b0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        sh[k] <= '0;
      end
    end else begin
      if (issue) begin
        ptr <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      busy <= (busy | grant) & ~rsp_onehot;

      sh[0] <= '{vld: issue, tag: gnt_idx, dz: issue && (sel_divisor == 8'h00)};
      for (int k = 1; k < PIPE_LAT; k++) begin
        sh[k] <= sh[k-1];
      end

      case ({issue, last.vld})
        2'b10:   bus.inflight <= bus.inflight + 4'd1;
        2'b01:   bus.inflight <= bus.inflight - 4'd1;
        default: bus.inflight <= bus.inflight;
      endcase

      bus.rsp_valid <= rsp_onehot;
      bus.rsp_dz    <= last.vld & last.dz;
      // Result data only moves with a real response; idle-slot divider output is never exposed.
      if (last.vld) begin
        if (last.dz) begin
          bus.rsp_quotient  <= 8'hFF;
          bus.rsp_remainder <= 8'h00;
        end else begin
          bus.rsp_quotient  <= bus.div_quotient;
          bus.rsp_remainder <= bus.div_remainder;
        end
      end
    end
  end

endmodule
